// File: rtl/ppl_pkg.sv
// Shared constants and shading helper for the ray-march exit stage.
package ppl_pkg;

  // Colour of a ray that ran out of steps without hitting anything.
  localparam logic [15:0] SKY_RGB565 = 16'h867D;

  // Block-id palette (RGB565 base colours).
  localparam logic [3:0]  BLK_GRASS   = 4'd1;
  localparam logic [3:0]  BLK_DIRT    = 4'd2;
  localparam logic [3:0]  BLK_STONE   = 4'd3;
  localparam logic [15:0] PAL_GRASS   = 16'h07E0;
  localparam logic [15:0] PAL_DIRT    = 16'h8A22;
  localparam logic [15:0] PAL_STONE   = 16'h8410;
  localparam logic [15:0] PAL_DEFAULT = 16'hFFFF;

  // Axis of the voxel face crossed by the ray; code 3 is shaded like X.
  typedef enum logic [1:0] {
    FACE_X     = 2'd0,
    FACE_Y     = 2'd1,
    FACE_Z     = 2'd2,
    FACE_X_ALT = 2'd3
  } face_e;

  localparam int MAX_STEPS_DEF = 15;

  // Scale each RGB565 channel by k/16 (k in 0..16), truncating.
  // 10-bit products are enough: 63 * 16 = 1008.
  function automatic logic [15:0] rgb565_scale(input logic [15:0] color,
                                               input logic [4:0]  k);
    logic [9:0] r_s;
    logic [9:0] g_s;
    logic [9:0] b_s;
    r_s = ({5'd0, color[15:11]} * {5'd0, k}) >> 4;
    g_s = ({4'd0, color[10:5]}  * {5'd0, k}) >> 4;
    b_s = ({5'd0, color[4:0]}   * {5'd0, k}) >> 4;
    return {5'(r_s), 6'(g_s), 5'(b_s)};
  endfunction

endpackage

// File: rtl/ppl_exit_if.sv
// Framebuffer write port of the exit stage.
// Handshake: a beat transfers on a rising clk edge where pix_wr_valid and
// pix_wr_ready are both high; once valid is raised, addr/data hold steady
// and valid stays high until that transfer happens; ready may toggle freely.
interface ppl_exit_if;
  logic        pix_wr_valid;
  logic        pix_wr_ready;
  logic [19:0] pix_wr_addr;
  logic [15:0] pix_wr_data;

  modport master (output pix_wr_valid, output pix_wr_addr, output pix_wr_data,
                  input  pix_wr_ready);
  modport slave  (input  pix_wr_valid, input  pix_wr_addr, input  pix_wr_data,
                  output pix_wr_ready);
endinterface

// File: rtl/pix_fifo.sv
// Synchronous FIFO for retired pixels {addr, rgb565}; registered storage, no
// same-cycle bypass from push to the head.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  // Head reads as zero while empty so the write port idles at 0.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents are only observable through the gated head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ppl_exit.sv
// Exit stage of the voxel ray-march pipeline: retires rays, shades them to
// RGB565, buffers them for the framebuffer and counts frame completion.
module ppl_exit
  import ppl_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int MAX_STEPS  = MAX_STEPS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        hit,
  input  logic [3:0]                  block_id,
  input  logic [1:0]                  hit_face,
  input  logic [3:0]                  block_cnt_out,
  input  logic [19:0]                 pixel_addr_out,
  output logic                        next_en,
  output logic                        ppl_hold,
  output logic                        frame_done,
  output logic [19:0]                 dbg_frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count,
  ppl_exit_if.master                  pix_wr
);
  localparam logic [19:0] FRAME_LAST  = 20'(H_DISP * V_DISP - 1);
  localparam logic [4:0]  MAX_STEPS_V = 5'(MAX_STEPS);

  logic        w_retire;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_accept;
  logic [15:0] w_base;
  logic [4:0]  w_k_lin;
  logic [6:0]  w_k_x3;
  logic [4:0]  w_k;
  logic [15:0] w_colour;
  logic [35:0] w_head;
  logic [19:0] r_frame_cnt;
  logic        r_frame_done;

  // Retire on a hit or when the step budget is used up.
  assign w_retire = in_valid & (hit | ({1'b0, block_cnt_out} >= MAX_STEPS_V));
  assign ppl_hold = ~rst & w_retire & w_full;
  assign next_en  = ~rst & ~ppl_hold & (~in_valid | w_retire);
  assign w_push   = ~rst & w_retire & ~w_full;
  assign w_accept = ~w_empty & pix_wr.pix_wr_ready;

  // Palette lookup for the hit block type.
  always_comb begin
    w_base = PAL_DEFAULT;
    case (block_id)
      BLK_GRASS: w_base = PAL_GRASS;
      BLK_DIRT:  w_base = PAL_DIRT;
      BLK_STONE: w_base = PAL_STONE;
      default:   w_base = PAL_DEFAULT;
    endcase
  end

  // Distance shading: darker with more steps, Z faces a further 3/4.
  assign w_k_lin  = 5'd16 - {1'b0, block_cnt_out};
  assign w_k_x3   = {2'b00, w_k_lin} * 7'd3;
  assign w_k      = (hit_face == FACE_Z) ? 5'(w_k_x3 >> 2) : w_k_lin;
  assign w_colour = hit ? rgb565_scale(w_base, w_k) : SKY_RGB565;

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(36)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({pixel_addr_out, w_colour}),
    .i_pop   (w_accept),
    .o_rdata (w_head),
    .o_count (dbg_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pix_wr.pix_wr_valid = ~w_empty;
  assign pix_wr.pix_wr_addr  = w_head[35:16];
  assign pix_wr.pix_wr_data  = w_head[15:0];

  // Count accepted writes; pulse frame_done after the last pixel of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 20'd1;
        end
      end
    end
  end

  assign frame_done    = r_frame_done;
  assign dbg_frame_cnt = r_frame_cnt;
endmodule
